// File: rtl/ex_stage.sv
// Execute stage: ALU, destination select and a radix-2 iterative multiply/divide unit.
// Optional `define MDU_SIGNED_EN makes MULT/DIV use two's-complement operands; otherwise they run as MULTU/DIVU.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [31:0] imm,
    input  logic [4:0]  shamt,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic        regdst,
    input  logic [3:0]  aluop,
    input  logic [1:0]  alusrca,
    input  logic [1:0]  alusrcb,
    input  logic        mem2reg,
    input  logic        regwr,
    input  logic        memwr,
    input  logic [2:0]  md_op,
    output logic [31:0] alu_result,
    output logic [31:0] store_data,
    output logic [4:0]  wr_reg,
    output logic        zero,
    output logic        mem2reg_o,
    output logic        regwr_o,
    output logic        memwr_o,
    output logic        stall
);
    // state | meaning
    // IDLE  | waiting; md_op 1..4 loads operands and stalls
    // BUSY  | one iteration per cycle, counter 0..31, stalled
    // DONE  | result in HI/LO, md_op ignored, pipeline released
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_nx;
    logic        stall_fsm;
    logic [4:0]  cnt;
    logic [31:0] acc_hi, acc_lo, dvs, hi, lo;
    logic        is_div, neg_q, neg_r, div0;

    logic        md_start, op_div, op_sgn;
    logic [31:0] abs_a, abs_b;
    logic [32:0] mul_sum, div_sh;
    logic [33:0] div_diff;
    logic        div_ok;
    logic [31:0] step_hi, step_lo, res_hi, res_lo;
    logic [63:0] prod, prod_s;

    logic [31:0] a_op, b_op, alu_out;

    assign md_start = (md_op >= 3'd1) && (md_op <= 3'd4);
    assign op_div   = (md_op == 3'd2) || (md_op == 3'd4);
`ifdef MDU_SIGNED_EN
    assign op_sgn   = (md_op == 3'd3) || (md_op == 3'd4);
`else
    assign op_sgn   = 1'b0;
`endif
    assign abs_a = (op_sgn && rs_val[31]) ? -rs_val : rs_val;
    assign abs_b = (op_sgn && rt_val[31]) ? -rt_val : rt_val;

    // Multiply: shift-add with the multiplier in acc_lo. Divide: restoring, quotient shifts into acc_lo.
    assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, dvs} : 33'd0);
    assign div_sh   = {acc_hi, acc_lo[31]};
    assign div_diff = {1'b0, div_sh} - {2'b00, dvs};
    assign div_ok   = ~div_diff[33];

    always_comb begin
        step_hi = mul_sum[32:1];
        step_lo = {mul_sum[0], acc_lo[31:1]};
        if (is_div) begin
            step_hi = div_ok ? div_diff[31:0] : div_sh[31:0];
            step_lo = {acc_lo[30:0], div_ok};
        end
    end

    // Divide by zero keeps the all-ones quotient regardless of operand signs.
    assign prod   = {step_hi, step_lo};
    assign prod_s = neg_q ? -prod : prod;
    always_comb begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
        if (is_div) begin
            res_lo = (neg_q && !div0) ? -step_lo : step_lo;
            res_hi = neg_r ? -step_hi : step_hi;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            acc_hi <= 32'd0;
            acc_lo <= 32'd0;
            dvs    <= 32'd0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (md_start) begin
                    cnt    <= 5'd0;
                    is_div <= op_div;
                    acc_hi <= 32'd0;
                    acc_lo <= abs_a;
                    dvs    <= abs_b;
                    neg_q  <= op_sgn && (rs_val[31] ^ rt_val[31]);
                    neg_r  <= op_sgn && rs_val[31];
                    div0   <= (rt_val == 32'd0);
                end
                BUSY: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx  = state;
        stall_fsm = 1'b0;
        case (state)
            IDLE: if (md_start) begin
                state_nx  = BUSY;
                stall_fsm = 1'b1;
            end
            BUSY: begin
                stall_fsm = 1'b1;
                if (cnt == 5'd31) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign stall = stall_fsm & ~rst;

    always_comb begin
        case (alusrca)
            2'd0:    a_op = rs_val;
            2'd1:    a_op = {27'd0, shamt};
            default: a_op = 32'd0;
        endcase
        case (alusrcb)
            2'd0:    b_op = rt_val;
            2'd1:    b_op = imm;
            default: b_op = 32'd0;
        endcase
    end

    always_comb begin
        case (aluop)
            4'd0:    alu_out = a_op + b_op;
            4'd1:    alu_out = a_op - b_op;
            4'd2:    alu_out = a_op & b_op;
            4'd3:    alu_out = a_op | b_op;
            4'd4:    alu_out = a_op ^ b_op;
            4'd5:    alu_out = ~(a_op | b_op);
            4'd6:    alu_out = {31'd0, $signed(a_op) < $signed(b_op)};
            4'd7:    alu_out = {31'd0, a_op < b_op};
            4'd8:    alu_out = b_op << a_op[4:0];
            4'd9:    alu_out = b_op >> a_op[4:0];
            4'd10:   alu_out = $signed(b_op) >>> a_op[4:0];
            4'd11:   alu_out = {b_op[15:0], 16'h0000};
            default: alu_out = 32'd0;
        endcase
    end

    always_comb begin
        case (md_op)
            3'd5:    alu_result = hi;
            3'd6:    alu_result = lo;
            default: alu_result = alu_out;
        endcase
    end

    assign zero       = (alu_result == 32'd0);
    assign store_data = rt_val;
    assign wr_reg     = regdst ? rd : rt;
    assign mem2reg_o  = mem2reg & ~stall;
    assign regwr_o    = regwr & ~stall;
    assign memwr_o    = memwr & ~stall;
endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage: ALU table, routing, MDU timing/results and mid-operation reset.
module tb_ex_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rs_val, rt_val, imm;
    logic [4:0]  shamt, rt, rd;
    logic        regdst;
    logic [3:0]  aluop;
    logic [1:0]  alusrca, alusrcb;
    logic        mem2reg, regwr, memwr;
    logic [2:0]  md_op;
    logic [31:0] alu_result, store_data;
    logic [4:0]  wr_reg;
    logic        zero, mem2reg_o, regwr_o, memwr_o, stall;

    int nvec = 0;
    int nerr = 0;

    ex_stage dut (
        .clk(clk), .rst(rst), .rs_val(rs_val), .rt_val(rt_val), .imm(imm),
        .shamt(shamt), .rt(rt), .rd(rd), .regdst(regdst), .aluop(aluop),
        .alusrca(alusrca), .alusrcb(alusrcb), .mem2reg(mem2reg), .regwr(regwr),
        .memwr(memwr), .md_op(md_op), .alu_result(alu_result), .store_data(store_data),
        .wr_reg(wr_reg), .zero(zero), .mem2reg_o(mem2reg_o), .regwr_o(regwr_o),
        .memwr_o(memwr_o), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply_alu(input string tag, input logic [3:0] op, input logic [1:0] sa,
                             input logic [1:0] sb, input logic [31:0] rsv, input logic [31:0] rtv,
                             input logic [31:0] im, input logic [4:0] sh, input logic [31:0] exp,
                             input logic expz);
        aluop = op; alusrca = sa; alusrcb = sb;
        rs_val = rsv; rt_val = rtv; imm = im; shamt = sh;
        #1;
        chk(tag, alu_result, exp);
        chk({tag, "_zero"}, {31'd0, zero}, {31'd0, expz});
    endtask

    task automatic check_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        md_op = 3'd5; #1;
        chk({tag, "_hi"}, alu_result, exp_hi);
        md_op = 3'd6; #1;
        chk({tag, "_lo"}, alu_result, exp_lo);
        md_op = 3'd0; #1;
    endtask

    task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int  n;
        logic leak;
        n = 0;
        leak = 1'b0;
        @(posedge clk); #1;
        aluop = 4'd0; alusrca = 2'd0; alusrcb = 2'd0;
        rs_val = a; rt_val = b; md_op = op;
        regwr = 1'b1; memwr = 1'b1; mem2reg = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!stall) break;
            n++;
            if (regwr_o !== 1'b0 || memwr_o !== 1'b0 || mem2reg_o !== 1'b0) leak = 1'b1;
        end
        chk({tag, "_stall_cycles"}, 32'(n), 32'd33);
        chk({tag, "_bubble"}, {31'd0, leak}, 32'd0);
        chk({tag, "_done_regwr"}, {31'd0, regwr_o}, 32'd1);
        md_op = 3'd0; regwr = 1'b0; memwr = 1'b0; mem2reg = 1'b0;
        @(posedge clk); #1;
        check_hilo(tag, exp_hi, exp_lo);
    endtask

    initial begin
        rst = 1'b1;
        rs_val = 0; rt_val = 0; imm = 0; shamt = 0; rt = 0; rd = 0; regdst = 0;
        aluop = 0; alusrca = 0; alusrcb = 0; mem2reg = 0; regwr = 0; memwr = 0; md_op = 0;
        #12;
        chk("rst_alu_result", alu_result, 32'd0);
        chk("rst_store_data", store_data, 32'd0);
        chk("rst_wr_reg", {27'd0, wr_reg}, 32'd0);
        chk("rst_ctrl", {29'd0, mem2reg_o, regwr_o, memwr_o}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        md_op = 3'd1; #1;
        chk("rst_stall_mdop", {31'd0, stall}, 32'd0);
        md_op = 3'd0;
        @(negedge clk); rst = 1'b0;

        apply_alu("add_wrap", 4'd0, 2'd0, 2'd1, 32'h7FFFFFFF, 32'd0, 32'd1, 5'd0, 32'h80000000, 1'b0);
        apply_alu("sub_zero", 4'd1, 2'd0, 2'd0, 32'd5, 32'd5, 32'd0, 5'd0, 32'd0, 1'b1);
        apply_alu("and",  4'd2, 2'd0, 2'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 5'd0, 32'hF000F000, 1'b0);
        apply_alu("or",   4'd3, 2'd0, 2'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 5'd0, 32'hFFF0FFF0, 1'b0);
        apply_alu("xor",  4'd4, 2'd0, 2'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 5'd0, 32'h0FF00FF0, 1'b0);
        apply_alu("nor",  4'd5, 2'd0, 2'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 5'd0, 32'h000F000F, 1'b0);
        apply_alu("slt",  4'd6, 2'd0, 2'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 5'd0, 32'd1, 1'b0);
        apply_alu("sltu", 4'd7, 2'd0, 2'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 5'd0, 32'd0, 1'b1);
        apply_alu("sll",  4'd8, 2'd1, 2'd0, 32'd0, 32'h0000000F, 32'd0, 5'd4, 32'h000000F0, 1'b0);
        apply_alu("sllv", 4'd8, 2'd0, 2'd0, 32'd33, 32'd1, 32'd0, 5'd0, 32'd2, 1'b0);
        apply_alu("srl",  4'd9, 2'd1, 2'd0, 32'd0, 32'hF0000000, 32'd0, 5'd4, 32'h0F000000, 1'b0);
        apply_alu("sra",  4'd10, 2'd1, 2'd0, 32'd0, 32'hF0000000, 32'd0, 5'd4, 32'hFF000000, 1'b0);
        apply_alu("lui",  4'd11, 2'd0, 2'd1, 32'd0, 32'd0, 32'h00001234, 5'd0, 32'h12340000, 1'b0);
        apply_alu("op12", 4'd12, 2'd0, 2'd0, 32'd5, 32'd7, 32'd0, 5'd0, 32'd0, 1'b1);
        apply_alu("srca2", 4'd0, 2'd2, 2'd0, 32'h123, 32'd5, 32'd0, 5'd0, 32'd5, 1'b0);
        apply_alu("srcb3", 4'd0, 2'd0, 2'd3, 32'h77, 32'd5, 32'd9, 5'd0, 32'h77, 1'b0);

        rt = 5'd3; rd = 5'd9; regdst = 1'b1; rt_val = 32'hCAFE0001;
        regwr = 1'b1; memwr = 1'b0; mem2reg = 1'b1; #1;
        chk("wr_reg_rd", {27'd0, wr_reg}, 32'd9);
        chk("store_data", store_data, 32'hCAFE0001);
        chk("ctrl_pass", {29'd0, mem2reg_o, regwr_o, memwr_o}, 32'h6);
        regdst = 1'b0; #1;
        chk("wr_reg_rt", {27'd0, wr_reg}, 32'd3);
        regwr = 1'b0; mem2reg = 1'b0;

        run_md("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_md("divu_by0", 3'd2, 32'd10, 32'd0, 32'h0000000A, 32'hFFFFFFFF);
        run_md("divu_100_7", 3'd2, 32'd100, 32'd7, 32'd2, 32'd14);
`ifdef MDU_SIGNED_EN
        run_md("div_m7_2", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_md("mult_m1_2", 3'd3, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_md("div_min_m1", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
`else
        run_md("div_m7_2", 3'd4, 32'hFFFFFFF9, 32'd2, 32'd1, 32'h7FFFFFFC);
        run_md("mult_m1_2", 3'd3, 32'hFFFFFFFF, 32'd2, 32'd1, 32'hFFFFFFFE);
        run_md("div_min_m1", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
`endif

        // Leave nonzero HI/LO behind, then reset at BUSY counter 10.
        run_md("multu_pre", 3'd1, 32'h00010000, 32'h00030000, 32'h00000003, 32'h00000000);
        @(posedge clk); #1;
        rs_val = 32'd5; rt_val = 32'd7; md_op = 3'd1;
        repeat (12) @(negedge clk);
        chk("busy_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1; md_op = 3'd0; #1;
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        check_hilo("midrst", 32'd0, 32'd0);
        @(negedge clk); rst = 1'b0;
        run_md("multu_3_4", 3'd1, 32'd3, 32'd4, 32'd0, 32'h0000000C);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 rs_val, rt_val, imm  in  32 each  register operands and extended immediate from ID/EX.
REQ-005 shamt, rt, rd  in  5 each  shift amount and destination candidates.
REQ-006 regdst  in  1  1 selects rd, 0 selects rt.
REQ-007 aluop  in  4  ALU operation code.
REQ-008 alusrca, alusrcb  in  2 each  operand A and operand B select.
REQ-009 mem2reg, regwr, memwr  in  1 each  control passed downstream.
REQ-010 md_op  in  3  multiply/divide op: 0 none, 1 MULTU, 2 DIVU, 3 MULT, 4 DIV, 5 MFHI, 6 MFLO, 7 no-op.
REQ-011 alu_result  out  32  ALU result, or HI/LO for MFHI/MFLO.
REQ-012 store_data  out  32  equals rt_val.
REQ-013 wr_reg  out  5  regdst ? rd : rt.
REQ-014 zero  out  1  alu_result == 0.
REQ-015 mem2reg_o, regwr_o, memwr_o  out  1 each  gated control.
REQ-016 stall  out  1  hold PC, IF/ID and ID/EX this cycle.

Function
REQ-017 Operand A SHALL be rs_val, zero-extended shamt, 0 or 0 for alusrca 0, 1, 2 or 3 respectively.
REQ-018 Operand B SHALL be rt_val, imm, 0 or 0 for alusrcb 0, 1, 2 or 3 respectively.
REQ-019 aluop SHALL select ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA and LUI for codes 0 to 11.
- All arithmetic wraps modulo 2^32; no overflow trap.
- Shifts shift B by A[4:0].
- LUI yields {B[15:0],16'h0}.
- Codes 12 to 15 yield 0.
REQ-020 md_op 5 or 6 SHALL override alu_result with HI or LO respectively.
REQ-021 The MDU SHALL be a 3-state FSM.
- IDLE: md_op 1 to 4 loads the operands, clears the counter, goes to BUSY and asserts stall in that same cycle.
- BUSY: one radix-2 iteration per cycle for 32 cycles (counter 0 to 31); stall=1 throughout.
- At counter 31 the FSM writes HI/LO and goes to DONE.
- DONE: stall=0 and md_op is ignored for one cycle; the FSM then returns to IDLE.
REQ-022 Any nonzero md_op other than 7 in BUSY SHALL keep stall=1, including an MFHI/MFLO interlock.
REQ-023 A multiply SHALL write HI:LO with the 64-bit product.
REQ-024 A divide SHALL write LO with the quotient and HI with the remainder.
REQ-025 Division by zero SHALL complete in the normal time and give LO=32'hFFFFFFFF, HI=dividend.
REQ-026 Total MDU latency SHALL be 33 stall cycles followed by 1 DONE cycle.
REQ-027 While stall=1, regwr_o, memwr_o and mem2reg_o SHALL be 0 so a bubble is injected downstream; otherwise they equal their inputs.
REQ-028 alu_result, wr_reg, zero and store_data SHALL be combinational from the inputs and HI/LO.

Reset
REQ-029 rst SHALL force the FSM to IDLE and clear the counter, HI and LO, even mid-operation; the partial result is discarded.
REQ-030 During and after reset, stall SHALL be 0; with all-zero inputs every output is 0.

Configuration
REQ-031 With MDU_SIGNED_EN defined, MULT/DIV SHALL use two's-complement operands.
- Quotient sign is the XOR of the operand signs; remainder sign follows the dividend.
- 32'h80000000 / -1 gives LO=32'h80000000, HI=0.
REQ-032 With MDU_SIGNED_EN undefined, md_op 3 and 4 SHALL execute as MULTU and DIVU.

Verification
REQ-033 ADD rs=7FFFFFFF, B=1 -> alu_result=80000000, zero=0; SUB 5-5 -> 0, zero=1.
REQ-034 SRA shamt=4, rt=F0000000 (alusrca=1) -> FF000000; LUI imm=1234 -> 12340000.
REQ-035 MULTU FFFFFFFF*FFFFFFFF -> stall=1 for 33 cycles with regwr_o=0; then HI=FFFFFFFE, LO=00000001; MFHI next returns FFFFFFFE.
REQ-036 DIV (signed build) -7/2 -> LO=FFFFFFFD, HI=FFFFFFFF; DIVU 10/0 -> LO=FFFFFFFF, HI=0000000A.
REQ-037 rst pulsed at BUSY counter 10 -> stall=0 at once, HI=LO=0; new MULTU 3*4 afterwards -> LO=0000000C.
